// File: rtl/uart_rx_ms.sv
`timescale 1ns/1ps
// uart_rx_ms: 16x oversampling UART receiver with 2-of-3 majority bit
// decision, optional parity, stop-bit checks and a single held output word.
module uart_rx_ms #(
   parameter int unsigned CLK_DIV   = 54,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx_pin,
   output logic [DATA_BITS-1:0] data_rx,
   output logic                 data_vld,
   input  logic                 data_ack,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 overrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;

   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

   logic                 r_sync1, r_sync2;
   logic [1:0]           r_warm;
   logic                 r_armed;
   logic [15:0]          r_div;
   logic [2:0]           r_state;
   logic [3:0]           r_os;
   logic [3:0]           r_bit;
   logic                 r_s7, r_s8;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr, r_ferr;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_vld, r_perr_o, r_ferr_o, r_brk_o, r_ovr;

   logic w_tick, w_mid, w_end, w_maj, w_fall, w_done, w_ferr_new, w_par;

   assign w_tick     = (r_div == DIV_LAST);
   assign w_mid      = w_tick && (r_os == 4'd9);
   assign w_end      = w_tick && (r_os == 4'd15);
   assign w_maj      = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
   // r_armed records that the real (post-reset) line was high last cycle, so a
   // line already low when reset releases never looks like a falling edge.
   assign w_fall     = r_armed && !r_sync2;
   assign w_done     = (r_state == S_STOP) && w_mid && (r_bit == STOP_LAST);
   assign w_ferr_new = r_ferr | ~w_maj;
   assign w_par      = ^{r_shift, w_maj};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_warm  <= '0;
         r_armed <= 1'b0;
         r_div   <= '0;
      end else begin
         r_sync1 <= rx_pin;
         r_sync2 <= r_sync1;
         r_warm  <= {r_warm[0], 1'b1};
         r_armed <= r_warm[1] & r_sync2;
         r_div   <= w_tick ? '0 : r_div + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_os    <= '0;
         r_bit   <= '0;
         r_s7    <= 1'b1;
         r_s8    <= 1'b1;
         r_shift <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         if (w_tick) r_os <= r_os + 4'd1;
         if (w_tick && (r_os == 4'd7)) r_s7 <= r_sync2;
         if (w_tick && (r_os == 4'd8)) r_s8 <= r_sync2;
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_os    <= '0;
                  r_bit   <= '0;
                  r_perr  <= 1'b0;
                  r_ferr  <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_mid && w_maj) r_state <= S_IDLE;
               else if (w_end)     r_state <= S_DATA;
            end
            S_DATA: begin
               if (w_mid) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
               if (w_end) begin
                  if (r_bit == DATA_LAST) begin
                     r_bit   <= '0;
                     r_state <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     r_bit <= r_bit + 4'd1;
                  end
               end
            end
            S_PAR: begin
               if (w_mid) r_perr <= (PARITY == 1) ? ~w_par : w_par;
               if (w_end) r_state <= S_STOP;
            end
            S_STOP: begin
               if (w_mid) begin
                  r_ferr <= w_ferr_new;
                  if (r_bit == STOP_LAST) r_state <= S_IDLE;
               end
               if (w_end) r_bit <= r_bit + 4'd1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A completion coinciding with an accepted ack replaces the word in place.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data   <= '0;
         r_vld    <= 1'b0;
         r_perr_o <= 1'b0;
         r_ferr_o <= 1'b0;
         r_brk_o  <= 1'b0;
         r_ovr    <= 1'b0;
      end else if (w_done) begin
         if (!r_vld || data_ack) begin
            r_data   <= r_shift;
            r_perr_o <= r_perr;
            r_ferr_o <= w_ferr_new;
            r_brk_o  <= (r_shift == '0) && w_ferr_new;
            r_vld    <= 1'b1;
         end else begin
            r_ovr <= 1'b1;
         end
      end else if (r_vld && data_ack) begin
         r_vld <= 1'b0;
         r_ovr <= 1'b0;
      end
   end

   assign data_rx    = r_data;
   assign data_vld   = r_vld;
   assign parity_err = r_perr_o;
   assign frame_err  = r_ferr_o;
   assign break_det  = r_brk_o;
   assign overrun    = r_ovr;

endmodule
